qsys_pio_in_multi: RTL

Parametrised multi-channel Avalon-MM input PIO slave for the Qsys system: it samples `NUM_CH` independent sensor/status buses of `DATA_W` bits each through a two-flop synchroniser and returns the selected channel on a registered `readdata`. It also provides per-channel change capture with a maskable, level-sensitive interrupt. It replaces per-sensor single-word input PIOs (one per BMP280 calibration/measurement word) with a single instance on the system interconnect.

---
 rtl/qsys_pio_pkg.sv | 26 ++
 rtl/qsys_pio_sync2.sv | 32 +++
 rtl/qsys_pio_in_multi.sv | 110 +++++++++++
 3 files changed

// File: rtl/qsys_pio_pkg.sv
// Shared constants and helpers for the multi-channel input PIO.
// Register offsets are derived from the word-address width so they track ADDR_W.
package qsys_pio_pkg;

  localparam int PIO_WARMUP  = 3;
  localparam int PIO_BUS_MAX = 14 * 32;

  // MASK and EDGE sit at the top two word addresses.
  function automatic int unsigned pio_mask_ofs(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd2;
  endfunction

  function automatic int unsigned pio_edge_ofs(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

  // Channel ch of a zero-padded input bus, zero-extended to 32 bits.
  function automatic logic [31:0] pio_chan_word(input logic [PIO_BUS_MAX-1:0] bus,
                                                input int unsigned data_w,
                                                input int unsigned ch);
    logic [31:0] m;
    m = (data_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << data_w) - 32'd1);
    return 32'(bus >> (ch * data_w)) & m;
  endfunction

endpackage

// File: rtl/qsys_pio_sync2.sv
// Two-flop synchroniser for an arbitrary-width bus, synchronous active-low reset.
module qsys_pio_sync2
  import qsys_pio_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_d, s1_q, s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/qsys_pio_in_multi.sv
// Multi-channel Avalon-MM input PIO with registered readback. Change capture,
// irq mask and level irq are built only when QSYS_PIO_EDGE_CAPTURE_EN is defined.
module qsys_pio_in_multi
  import qsys_pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  output logic                     irq
);

  localparam int BUS_W = NUM_CH * DATA_W;
  localparam logic [ADDR_W-1:0] MASK_ADDR = ADDR_W'(pio_mask_ofs(ADDR_W));
  localparam logic [ADDR_W-1:0] EDGE_ADDR = ADDR_W'(pio_edge_ofs(ADDR_W));

  logic [BUS_W-1:0]       sync2;
  logic [PIO_BUS_MAX-1:0] sync2_pad;
  logic [31:0]            readdata_d, readdata_q;
  logic [NUM_CH-1:0]      mask_rd, edge_rd;
  logic                   unused_wr;

  qsys_pio_sync2 #(.W(BUS_W)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync2)
  );

  // Avalon: a write lands when chipselect & write are high at a clk edge;
  // readdata always reflects the address sampled at the previous edge.
  assign unused_wr = ^{chipselect, write, writedata};

`ifdef QSYS_PIO_EDGE_CAPTURE_EN
  logic [BUS_W-1:0]  prev_d, prev_q;
  logic [NUM_CH-1:0] capture_d, capture_q, mask_d, mask_q, changed, clear;
  logic [1:0]        warm_d, warm_q;
  logic              irq_d, irq_q, wr_en, warm_done;

  always_comb begin
    wr_en     = chipselect & write;
    warm_done = (warm_q == 2'(PIO_WARMUP));
    warm_d    = warm_done ? warm_q : warm_q + 2'd1;
    prev_d    = sync2;
    changed   = '0;
    for (int c = 0; c < NUM_CH; c++)
      changed[c] = |(sync2[c*DATA_W +: DATA_W] ^ prev_q[c*DATA_W +: DATA_W]);
    clear     = (wr_en && address == EDGE_ADDR) ? writedata[NUM_CH-1:0] : '0;
    // A new change in the same cycle as its clear wins.
    capture_d = (capture_q & ~clear) | (warm_done ? changed : '0);
    mask_d    = (wr_en && address == MASK_ADDR) ? writedata[NUM_CH-1:0] : mask_q;
    irq_d     = |(capture_q & mask_q);
    mask_rd   = mask_q;
    edge_rd   = capture_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q    <= '0;
      capture_q <= '0;
      mask_q    <= '0;
      warm_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      capture_q <= capture_d;
      mask_q    <= mask_d;
      warm_q    <= warm_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  always_comb begin
    mask_rd = '0;
    edge_rd = '0;
  end

  assign irq = 1'b0;
`endif

  always_comb begin
    sync2_pad             = '0;
    sync2_pad[BUS_W-1:0]  = sync2;
    readdata_d            = '0;
    if (address < ADDR_W'(NUM_CH))
      readdata_d = pio_chan_word(sync2_pad, DATA_W, 32'(address));
    else if (address == MASK_ADDR)
      readdata_d = 32'(mask_rd);
    else if (address == EDGE_ADDR)
      readdata_d = 32'(edge_rd);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;

endmodule
